// File: rtl/apb_master.sv
// APB initiator: single-beat read/write commands in, SETUP/ACCESS on the bus, one-cycle response strobe out.
// Optional ACCESS wait timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("apb_master: TIMEOUT must be at least 1");
        end
    endgenerate

    // Gated by rst so a command presented during reset is never handshaked.
    assign cmd_ready = (state == IDLE) && !rst;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // True on the edge that would be the TIMEOUT-th consecutive low-pready ACCESS edge.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timed_out) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master with a behavioural APB slave memory and reference memory.
module tb_apb_master;

    logic        pclk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic        pready;
    logic [15:0] prdata;

    int compared   = 0;
    int mismatched = 0;

    // ref_mem is what the controller should observe; slave_mem is what the bus actually wrote.
    logic [15:0] ref_mem   [256];
    logic [15:0] slave_mem [256];

    apb_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(16)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transfer. The slave keeps pready low for 'waits' ACCESS cycles and then drives
    // final_ready; final_ready=0 models a slave that never answers (timeout abort expected).
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                                 input int waits, input logic final_ready, input logic hold);
        logic        err;
        logic [15:0] exp_rdata;
        int          guard;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge pclk); #1;
            guard++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_wait_expired", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        err       = !final_ready;
        exp_rdata = (wr || err) ? 16'h0 : ref_mem[addr];
        if (wr && !err) ref_mem[addr] = wdata;

        @(posedge pclk); #1;
        if (!hold) cmd_valid = 1'b0;
        pready = 1'($urandom);
        prdata = 16'($urandom);
        checkOutput("setup_psel", psel, 1);
        checkOutput("setup_penable", penable, 0);
        checkOutput("setup_cmd_ready", cmd_ready, 0);
        checkOutput("setup_rsp_valid", rsp_valid, 0);
        checkOutput("setup_paddr", paddr, addr);
        checkOutput("setup_pwrite", pwrite, wr);
        checkOutput("setup_pwdata", pwdata, wdata);

        @(posedge pclk); #1;
        for (int i = 0; i <= waits; i++) begin
            pready = (i == waits) ? final_ready : 1'b0;
            prdata = pwrite ? 16'($urandom) : slave_mem[paddr];
            checkOutput("access_psel", psel, 1);
            checkOutput("access_penable", penable, 1);
            checkOutput("access_paddr", paddr, addr);
            checkOutput("access_pwrite", pwrite, wr);
            checkOutput("access_pwdata", pwdata, wdata);
            checkOutput("access_cmd_ready", cmd_ready, 0);
            checkOutput("access_rsp_valid", rsp_valid, 0);
            if (pready && pwrite) slave_mem[paddr] = pwdata;
            @(posedge pclk); #1;
        end

        pready = 1'($urandom);
        prdata = 16'($urandom);
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_err", rsp_err, err);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_psel", psel, 0);
        checkOutput("rsp_penable", penable, 0);
        checkOutput("rsp_cmd_ready", cmd_ready, 1);
        checkOutput("rsp_paddr_held", paddr, addr);
        checkOutput("rsp_pwdata_held", pwdata, wdata);

        if (!hold) begin
            @(posedge pclk); #1;
            checkOutput("post_rsp_valid", rsp_valid, 0);
            checkOutput("post_rsp_rdata_held", rsp_rdata, exp_rdata);
            checkOutput("post_psel", psel, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 16'($urandom);
            slave_mem[i] = ref_mem[i];
        end

        // Reset with a command already presented: outputs zero, nothing accepted.
        rst       = 1'b1;
        pready    = 1'b1;
        prdata    = 16'h1234;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h3C;
        cmd_wdata = 16'hBEEF;
        repeat (2) @(posedge pclk);
        #1;
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_psel", psel, 0);
        checkOutput("reset_penable", penable, 0);
        checkOutput("reset_pwrite", pwrite, 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        rst       = 1'b0;
        @(posedge pclk); #1;
        checkOutput("idle_cmd_ready", cmd_ready, 1);

        // Directed scenarios from the test plan.
        applyStimulus(1'b1, 8'h00, 16'hAA55, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 16'h0000, 0, 1'b1, 1'b0);
        checkOutput("slave_mem0", slave_mem[0], 16'hAA55);
        applyStimulus(1'b1, 8'h0B, 16'hAA56, 3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h0C, 16'hAA56, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h0C, 16'h0000, 0, 1'b1, 1'b1);
        cmd_valid = 1'b0;
        @(posedge pclk); #1;

        // Reset asserted mid-ACCESS with the slave stalling; the write must be dropped.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h05;
        cmd_wdata = 16'h5A5A;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        checkOutput("stall_penable", penable, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_psel", psel, 0);
        checkOutput("async_penable", penable, 0);
        checkOutput("async_rsp_valid", rsp_valid, 0);
        checkOutput("async_cmd_ready", cmd_ready, 0);
        pready = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            checkOutput("post_reset_rsp_valid", rsp_valid, 0);
            checkOutput("post_reset_psel", psel, 0);
        end
        pready = 1'b0;
        applyStimulus(1'b0, 8'h05, 16'h0000, 1, 1'b1, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave aborts on the 16th low-pready edge; pready on that edge wins instead.
        applyStimulus(1'b0, 8'h07, 16'h0000, 15, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h07, 16'hC3C3, 15, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h08, 16'h3C3C, 15, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h08, 16'h0000, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h07, 16'h0000, 2, 1'b1, 1'b0);
`endif

        // Randomized traffic over a small address window so reads hit earlier writes.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom),
                          int'($urandom_range(0, 3)), 1'b1, 1'($urandom));
        end
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("final_slave_mem", slave_mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
